// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes and state encodings for the pipeline run/step controller,
// used by the debug unit and the datapath top.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_STEP  = 2'd1,
    CMD_HALT  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_SNAP = 3'd3,
    ST_DONE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/pipe_en_chain.sv
// Per-stage enable/clear generation: a stall at stage k freezes every stage
// upstream of it; flush and the global clear act independently of enables.
module pipe_en_chain #(
  parameter int NUM_STAGES = 5
) (
  input  logic                  i_active,
  input  logic                  i_clr_all,
  input  logic [NUM_STAGES-1:0] i_stall,
  input  logic [NUM_STAGES-1:0] i_flush,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [NUM_STAGES-1:0] o_stage_clr
);

  // w_stall_sfx[i] = OR of stall requests from stage i up to the last stage
  logic [NUM_STAGES:0] w_stall_sfx;
  assign w_stall_sfx[NUM_STAGES] = 1'b0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    assign w_stall_sfx[g]  = w_stall_sfx[g+1] | i_stall[g];
    assign o_stage_en[g]   = i_active & ~w_stall_sfx[g];
    assign o_stage_clr[g]  = i_clr_all | (i_active & i_flush[g]);
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Pipeline run/step controller: RUN/STEP/HALT/CLEAR debug modes merged with
// hazard stalls/flushes, stop snapshot handshake and executed-cycle counter.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int STEP_W     = 8,
  parameter int CYC_W      = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [STEP_W-1:0]     i_cmd_steps,
  input  logic [NUM_STAGES-1:0] i_hazard_stall,
  input  logic [NUM_STAGES-1:0] i_hazard_flush,
  input  logic                  i_eop,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [NUM_STAGES-1:0] o_stage_clr,
  output logic [2:0]            o_ctrl_state,
  output logic                  o_snapshot_req,
  input  logic                  i_snapshot_ack,
  output logic [CYC_W-1:0]      o_cycle_count
);

  ctrl_state_t       r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step_left, w_step_nxt;
  logic [CYC_W-1:0]  r_cycle_count;
  logic              r_stop_eop, w_stop_eop_nxt;
  logic              r_clr_pulse;

  logic w_active, w_accept, w_clear, w_halt;

  // eop gates execution in the very cycle it is seen so the EOP instruction survives
  assign w_active    = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !i_eop && i_reset;
  assign o_cmd_ready = i_reset && (r_state != ST_SNAP);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_clear     = w_accept && (cmd_op_t'(i_cmd_op) == CMD_CLEAR);
  assign w_halt      = w_accept && (cmd_op_t'(i_cmd_op) == CMD_HALT);

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step_left;
    w_stop_eop_nxt = r_stop_eop;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && cmd_op_t'(i_cmd_op) == CMD_RUN) begin
          w_state_nxt = ST_RUN;
        end else if (w_accept && cmd_op_t'(i_cmd_op) == CMD_STEP) begin
          w_state_nxt = ST_STEP;
          w_step_nxt  = (i_cmd_steps == '0) ? STEP_W'(1) : i_cmd_steps;
        end
      end
      ST_RUN: begin
        if (i_eop) begin
          w_state_nxt    = ST_SNAP;
          w_stop_eop_nxt = 1'b1;
        end else if (w_halt) begin
          w_state_nxt    = ST_SNAP;
          w_stop_eop_nxt = 1'b0;
        end
      end
      ST_STEP: begin
        // a stalled cycle still consumes a step
        if (i_eop) begin
          w_state_nxt    = ST_SNAP;
          w_stop_eop_nxt = 1'b1;
        end else if (w_halt || r_step_left <= STEP_W'(1)) begin
          w_state_nxt    = ST_SNAP;
          w_stop_eop_nxt = 1'b0;
          w_step_nxt     = '0;
        end else begin
          w_step_nxt = r_step_left - STEP_W'(1);
        end
      end
      ST_SNAP: begin
        if (i_snapshot_ack) w_state_nxt = r_stop_eop ? ST_DONE : ST_IDLE;
      end
      ST_DONE: ;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clear) begin
      w_state_nxt    = ST_IDLE;
      w_step_nxt     = '0;
      w_stop_eop_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_step_left   <= '0;
      r_cycle_count <= '0;
      r_stop_eop    <= 1'b0;
      r_clr_pulse   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_left <= w_step_nxt;
      r_stop_eop  <= w_stop_eop_nxt;
      r_clr_pulse <= w_clear;
      if (w_clear)
        r_cycle_count <= '0;
      else if (w_active && r_cycle_count != '1)
        r_cycle_count <= r_cycle_count + CYC_W'(1);
    end
  end

  pipe_en_chain #(.NUM_STAGES(NUM_STAGES)) u_en_chain (
    .i_active    (w_active),
    .i_clr_all   (!i_reset || r_clr_pulse),
    .i_stall     (i_hazard_stall),
    .i_flush     (i_hazard_flush),
    .o_stage_en  (o_stage_en),
    .o_stage_clr (o_stage_clr)
  );

  assign o_ctrl_state   = r_state;
  assign o_snapshot_req = i_reset && (r_state == ST_SNAP);
  assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: a default build plus a CYC_W=4 build sharing inputs.
module tb_pipe_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_steps = 8'd0;
  logic [4:0] stall = 5'd0, flush = 5'd0;
  logic       eop = 1'b0, ack = 1'b0;

  logic       ready, ready_s, req, req_s;
  logic [4:0] en, clr, en_s, clr_s;
  logic [2:0] st, st_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_en;

  always #5 clk = ~clk;

  pipe_run_ctrl dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready),
    .i_cmd_op(cmd_op), .i_cmd_steps(cmd_steps), .i_hazard_stall(stall),
    .i_hazard_flush(flush), .i_eop(eop), .o_stage_en(en), .o_stage_clr(clr),
    .o_ctrl_state(st), .o_snapshot_req(req), .i_snapshot_ack(ack), .o_cycle_count(cnt)
  );

  pipe_run_ctrl #(.NUM_STAGES(5), .STEP_W(8), .CYC_W(4)) dut_s (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready_s),
    .i_cmd_op(cmd_op), .i_cmd_steps(cmd_steps), .i_hazard_stall(stall),
    .i_hazard_flush(flush), .i_eop(eop), .o_stage_en(en_s), .o_stage_clr(clr_s),
    .o_ctrl_state(st_s), .o_snapshot_req(req_s), .i_snapshot_ack(ack), .o_cycle_count(cnt_s)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] steps);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = steps;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    #1;
    checks++; if (en !== 5'b00000) begin errors++; $display("FAIL rst_en: got %b want 00000", en); end
    checks++; if (clr !== 5'b11111) begin errors++; $display("FAIL rst_clr: got %b want 11111", clr); end
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", st); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cnt); end
    checks++; if (ready !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rst_ready_req: got %b%b want 00", ready, req); end
    rst_n = 1'b1;
    #1;
    checks++; if (clr !== 5'b00000) begin errors++; $display("FAIL rel_clr: got %b want 00000", clr); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", ready); end
    cyc();
  endtask

  task automatic test_step3();
    send_cmd(2'd1, 8'd3);
    repeat (3) exp_q.push_back(5'b11111);
    exp_q.push_back(5'b00000);
    for (int k = 0; k < 4; k++) begin
      exp_en = exp_q.pop_front();
      checks++; if (en !== exp_en) begin errors++; $display("FAIL step3_en[%0d]: got %b want %b", k, en, exp_en); end
      cyc();
    end
    checks++; if (st !== 3'd3 || req !== 1'b1) begin errors++; $display("FAIL step3_snap: got st=%0d req=%b want st=3 req=1", st, req); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL step3_ready: got %b want 0", ready); end
    cyc();
    do_ack();
    checks++; if (st !== 3'd0 || req !== 1'b0) begin errors++; $display("FAIL step3_idle: got st=%0d req=%b want st=0 req=0", st, req); end
    checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL step3_count: got %0d want 3", cnt); end
  endtask

  task automatic test_hazard();
    send_cmd(2'd0, 8'd0);
    stall = 5'b00100;
    flush = 5'b00100;
    #1;
    checks++; if (en !== 5'b11000) begin errors++; $display("FAIL haz_en: got %b want 11000", en); end
    checks++; if (clr !== 5'b00100) begin errors++; $display("FAIL haz_clr: got %b want 00100", clr); end
    cyc();
    stall = 5'b00000;
    flush = 5'b00000;
    #1;
    checks++; if (en !== 5'b11111 || clr !== 5'b00000) begin errors++; $display("FAIL haz_release: got en=%b clr=%b want 11111/00000", en, clr); end
    send_cmd(2'd2, 8'd0);
    checks++; if (st !== 3'd3 || en !== 5'b00000) begin errors++; $display("FAIL halt_snap: got st=%0d en=%b want 3/00000", st, en); end
    do_ack();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL halt_idle: got %0d want 0", st); end
  endtask

  task automatic test_eop();
    send_cmd(2'd3, 8'd0);
    checks++; if (clr !== 5'b11111 || st !== 3'd0) begin errors++; $display("FAIL clr_pulse: got clr=%b st=%0d want 11111/0", clr, st); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", cnt); end
    cyc();
    checks++; if (clr !== 5'b00000) begin errors++; $display("FAIL clr_once: got %b want 00000", clr); end
    send_cmd(2'd0, 8'd0);
    for (int c = 1; c <= 9; c++) begin
      exp_q.push_back(5'b11111);
      exp_en = exp_q.pop_front();
      checks++; if (en !== exp_en) begin errors++; $display("FAIL run_en[%0d]: got %b want %b", c, en, exp_en); end
      cyc();
    end
    eop = 1'b1;
    exp_q.push_back(5'b00000);
    #1;
    exp_en = exp_q.pop_front();
    checks++; if (en !== exp_en) begin errors++; $display("FAIL eop_en: got %b want %b", en, exp_en); end
    cyc();
    eop = 1'b0;
    #1;
    checks++; if (st !== 3'd3 || req !== 1'b1) begin errors++; $display("FAIL eop_snap: got st=%0d req=%b want 3/1", st, req); end
    checks++; if (cnt !== 32'd9) begin errors++; $display("FAIL eop_count: got %0d want 9", cnt); end
    do_ack();
    checks++; if (st !== 3'd4 || ready !== 1'b1) begin errors++; $display("FAIL eop_done: got st=%0d ready=%b want 4/1", st, ready); end
    send_cmd(2'd0, 8'd0);
    checks++; if (st !== 3'd4 || en !== 5'b00000) begin errors++; $display("FAIL done_run: got st=%0d en=%b want 4/00000", st, en); end
    send_cmd(2'd3, 8'd0);
    checks++; if (clr !== 5'b11111 || st !== 3'd0) begin errors++; $display("FAIL done_clear: got clr=%b st=%0d want 11111/0", clr, st); end
    cyc();
    checks++; if (clr !== 5'b00000) begin errors++; $display("FAIL done_clr_once: got %b want 00000", clr); end
  endtask

  task automatic test_step0();
    send_cmd(2'd1, 8'd0);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b00000);
    for (int k = 0; k < 2; k++) begin
      exp_en = exp_q.pop_front();
      checks++; if (en !== exp_en) begin errors++; $display("FAIL step0_en[%0d]: got %b want %b", k, en, exp_en); end
      cyc();
    end
    checks++; if (st !== 3'd3 || cnt !== 32'd1) begin errors++; $display("FAIL step0_snap: got st=%0d cnt=%0d want 3/1", st, cnt); end
    do_ack();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL step0_idle: got %0d want 0", st); end
  endtask

  task automatic test_eop_races();
    send_cmd(2'd1, 8'd1);
    eop = 1'b1;
    #1;
    checks++; if (en !== 5'b00000) begin errors++; $display("FAIL stepeop_en: got %b want 00000", en); end
    cyc();
    eop = 1'b0;
    do_ack();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL stepeop_done: got %0d want 4", st); end
    send_cmd(2'd3, 8'd0);
    send_cmd(2'd0, 8'd0);
    eop = 1'b1;
    send_cmd(2'd2, 8'd0);
    eop = 1'b0;
    do_ack();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL halteop_done: got %0d want 4", st); end
    send_cmd(2'd3, 8'd0);
  endtask

  task automatic test_saturate();
    send_cmd(2'd0, 8'd0);
    repeat (20) cyc();
    checks++; if (cnt_s !== 4'd15) begin errors++; $display("FAIL sat_small: got %0d want 15", cnt_s); end
    checks++; if (cnt !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", cnt); end
    checks++; if (en_s !== 5'b11111) begin errors++; $display("FAIL sat_en: got %b want 11111", en_s); end
    send_cmd(2'd2, 8'd0);
    do_ack();
  endtask

  task automatic test_reset_snap();
    send_cmd(2'd0, 8'd0);
    send_cmd(2'd2, 8'd0);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rsnap_req: got %b want 1", req); end
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || clr !== 5'b11111) begin errors++; $display("FAIL rsnap_drop: got req=%b clr=%b want 0/11111", req, clr); end
    cyc();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL rsnap_state: got %0d want 0", st); end
    rst_n = 1'b1;
    #1;
    checks++; if (req !== 1'b0 || st !== 3'd0 || cnt !== 32'd0) begin errors++; $display("FAIL rsnap_after: got req=%b st=%0d cnt=%0d want 0/0/0", req, st, cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_step3();
    test_hazard();
    test_eop();
    test_step0();
    test_eop_races();
    test_saturate();
    test_reset_snap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
